aes_round_pipe: RTL and testbench
=================================

Name: aes_round_pipe

Overview:
Parametrised AES-128 encryption round engine with a valid/ready handshake and per-transaction final-round mode. It applies SubBytes, ShiftRows, optional MixColumns and AddRoundKey to one 128-bit state per accepted transaction. The pipeline depth is 1 or 2 register stages, and a sideband tag travels with each transaction. It sits between the key-schedule/round controller and the cipher iteration loop, replacing the fixed single-mode round.

Parameters:
PIPE_STAGES, 1, number of register stages: 1 = all four steps in one cycle; 2 = register after ShiftRows.
TAG_W, 4, width of the sideband tag carried alongside each state.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents a transaction.
in_ready  output  1  block accepts a transaction this cycle.
in_state  input  128  [0:127] state; bits 0:7 are byte 0; column-major FIPS-197 order.
in_key  input  128  [0:127] round key, same byte order.
in_last  input  1  1 = final round (MixColumns bypassed).
in_tag  input  TAG_W  opaque tag, returned unchanged.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
out_state  output  128  [0:127] round result.
out_tag  output  TAG_W  tag of the transaction in out_state.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_state=0, out_tag=0, all internal stage-valid bits=0. in_ready=1 in the cycle after reset deasserts. reset overrides every handshake in the same cycle.
- Accept: a transaction is accepted when in_valid && in_ready at a rising edge.
- Deliver: a result is consumed when out_valid && out_ready at a rising edge.
- Datapath:
  - SubBytes uses 16 instances of the shared FIPS-197 S-box lookup.
  - ShiftRows rotates row r left by r bytes.
  - MixColumns is GF(2^8) multiplication by {02,03,01,01} with polynomial 0x11B, via xtime.
  - AddRoundKey is a 128-bit XOR with the key.
  - in_last=1 replaces the MixColumns output with its input.
- PIPE_STAGES=1:
  - Single output register stage.
  - Latency is 1: an accept at edge N gives out_valid=1 after edge N.
  - in_ready = !out_valid || out_ready, so full throughput is kept under continuous out_ready.
- PIPE_STAGES=2:
  - Stage A registers the ShiftRows result, plus key, last and tag.
  - Stage B registers the final result.
  - Latency is 2 edges.
  - stageB_ready = !out_valid || out_ready.
  - in_ready = !stageA_valid || stageB_ready, so one transaction per cycle is sustained.
- Stall:
  - While out_valid && !out_ready, out_state and out_tag hold stable.
  - Upstream stages advance only into empty or draining slots. No transaction is dropped or duplicated.
  - in_key and in_last are captured at accept. Later changes do not affect transactions already in flight.
- Ordering is strictly FIFO. The tag emerges with its own state.
- Reset mid-operation: all in-flight transactions are discarded with no output pulse. The next accepted transaction produces normal results.
- Not a legal configuration: a PIPE_STAGES value other than 1 or 2. It causes an elaboration error via a generate-time check.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready is to in_ready.

Test Plan:
- Normal round, PIPE_STAGES=1, out_ready=1: in_state=193de3bea0f4e22b9ac68d2ae9f84808, in_key=a0fafe1788542cb123a339392a6c7605, in_last=0, in_tag=3 -> one edge later out_valid=1, out_state=a49c7ff2689f352b6b5bea43026a5049, out_tag=3.
- Final round: in_state=eb40f21e592e38848ba113e71bc342d2, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6, in_last=1 -> out_state=3925841d02dc09fbdc118597196a0b32.
- PIPE_STAGES=2 streaming: issue both vectors above back-to-back, tags 1 then 2, out_ready=1 -> results appear on consecutive cycles after a 2-edge latency, in order, tags 1, 2; in_ready stays 1 throughout.
- Backpressure (both configurations): hold out_ready=0 for 5 cycles while in_valid=1 with distinct tags -> out_state and out_tag stay stable; in_ready drops once the pipeline is full (after 1 accept for PIPE_STAGES=1, after 2 for PIPE_STAGES=2); releasing out_ready delivers every tag exactly once, in order.
- Reset mid-flight: accept a transaction, assert reset on the next edge -> out_valid=0, out_state=0, out_tag=0, and no result for that transaction ever appears; a new transaction afterwards returns the correct value.
- Key change after accept: accept with the round-1 key, change in_key to all zeros in the following cycle -> result equals a49c7ff2689f352b6b5bea43026a5049.

Source files
------------

// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
// behind a valid/ready handshake, with one or two register stages and a sideband tag.
module aes_round_pipe #(
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in_state,
    input  logic [0:127]     in_key,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_state,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte index is row + 4*column; row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                   ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return o;
    endfunction

    logic [0:127] sub_bytes;
    logic [0:127] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            assign sub_bytes[8*gi +: 8] = sbox(in_state[8*gi +: 8]);
        end
    endgenerate

    assign shifted = shift_rows(sub_bytes);

    // Inputs of the output register: straight from the ports, or from stage A.
    logic             fin_valid;
    logic             fin_ready;
    logic [0:127]     fin_shifted;
    logic [0:127]     fin_key;
    logic             fin_last;
    logic [TAG_W-1:0] fin_tag;
    logic [0:127]     fin_mixed;

    logic             out_valid_q, out_valid_d;
    logic [0:127]     out_state_q, out_state_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    assign fin_ready = !out_valid_q || out_ready;

    generate
        if (PIPE_STAGES == 1) begin : g_one
            assign fin_valid   = in_valid;
            assign fin_shifted = shifted;
            assign fin_key     = in_key;
            assign fin_last    = in_last;
            assign fin_tag     = in_tag;
            assign in_ready    = fin_ready;
        end else if (PIPE_STAGES == 2) begin : g_two
            logic             a_valid_q, a_valid_d;
            logic [0:127]     a_state_q, a_state_d;
            logic [0:127]     a_key_q,   a_key_d;
            logic             a_last_q,  a_last_d;
            logic [TAG_W-1:0] a_tag_q,   a_tag_d;

            assign in_ready = !a_valid_q || fin_ready;

            always_comb begin
                a_valid_d = a_valid_q;
                a_state_d = a_state_q;
                a_key_d   = a_key_q;
                a_last_d  = a_last_q;
                a_tag_d   = a_tag_q;
                if (in_ready) begin
                    a_valid_d = in_valid;
                    if (in_valid) begin
                        a_state_d = shifted;
                        a_key_d   = in_key;
                        a_last_d  = in_last;
                        a_tag_d   = in_tag;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_valid_q <= 1'b0;
                    a_state_q <= '0;
                    a_key_q   <= '0;
                    a_last_q  <= 1'b0;
                    a_tag_q   <= '0;
                end else begin
                    a_valid_q <= a_valid_d;
                    a_state_q <= a_state_d;
                    a_key_q   <= a_key_d;
                    a_last_q  <= a_last_d;
                    a_tag_q   <= a_tag_d;
                end
            end

            assign fin_valid   = a_valid_q;
            assign fin_shifted = a_state_q;
            assign fin_key     = a_key_q;
            assign fin_last    = a_last_q;
            assign fin_tag     = a_tag_q;
        end else begin : g_bad
            $fatal(1, "aes_round_pipe: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_tag_d   = out_tag_q;
        fin_mixed   = fin_last ? fin_shifted : mix_columns(fin_shifted);
        if (fin_ready) begin
            out_valid_d = fin_valid;
            if (fin_valid) begin
                out_state_d = fin_mixed ^ fin_key;
                out_tag_d   = fin_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_aes_round_pipe.sv
// Bench for aes_round_pipe: a one-stage and a two-stage instance, each exercised in turn
// against an occupancy/queue model and an algebraic (GF inverse + affine) AES round model.
module tb_aes_round_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_state  [2];
    logic [127:0] in_key    [2];
    logic         in_last   [2];
    logic [3:0]   in_tag    [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_state [2];
    logic [3:0]   out_tag   [2];

    aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
        .in_key(in_key[0]), .in_last(in_last[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .out_tag(out_tag[0])
    );

    aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(4)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
        .in_key(in_key[1]), .in_last(in_last[1]), .in_tag(in_tag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .out_tag(out_tag[1])
    );

    int checks = 0;
    int errors = 0;
    int cur_d  = 0;

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        bit           last;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [4];

    typedef struct {
        logic [127:0] st;
        logic [3:0]   tag;
        int           age;
    } ent_t;
    ent_t q [$];

    logic [127:0] pend_exp;
    logic [7:0]   sb_tbl [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s stages=%0d actual=%h required=%h", name, cur_d + 1, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sb_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k,
                                                  input bit last);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) m[i%4][i/4] = sb_tbl[s[127-8*i -: 8]];
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++) t[rr][c] = m[rr][(c+rr)%4];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                m[rr][c] = last ? t[rr][c]
                                : gmul(t[rr][c], 8'h02) ^ gmul(t[(rr+1)%4][c], 8'h03)
                                  ^ t[(rr+2)%4][c] ^ t[(rr+3)%4][c];
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i%4][i/4] ^ k[127-8*i -: 8];
        return r;
    endfunction

    task automatic drive(input int d, input bit v, input logic [127:0] s, input logic [127:0] k,
                         input bit l, input logic [3:0] t, input bit ordy, input logic [127:0] e);
        in_valid[d]  = v;
        in_state[d]  = s;
        in_key[d]    = k;
        in_last[d]   = l;
        in_tag[d]    = t;
        out_ready[d] = ordy;
        pend_exp     = e;
    endtask

    // One clock: check outputs against the model at the falling edge, then advance the model.
    task automatic cycle(input int d);
        bit   eov;
        bit   erdy;
        bit   acc;
        bit   dlv;
        ent_t e;
        int   p;
        cur_d = d;
        p = d + 1;
        @(negedge clk);
        eov  = (q.size() > 0) && (q[0].age >= p);
        erdy = (q.size() < p) || (eov && out_ready[d]);
        chk("out_valid", 128'(out_valid[d]), 128'(eov));
        chk("in_ready", 128'(in_ready[d]), 128'(erdy));
        if (eov) begin
            chk("out_state", out_state[d], q[0].st);
            chk("out_tag", 128'(out_tag[d]), 128'(q[0].tag));
        end
        acc = in_valid[d] && erdy;
        dlv = eov && out_ready[d];
        @(posedge clk);
        #1;
        foreach (q[i]) q[i].age++;
        if (dlv) void'(q.pop_front());
        if (acc) begin
            e.st  = pend_exp;
            e.tag = in_tag[d];
            e.age = 1;
            q.push_back(e);
        end
        $display("stages=%0d acc=%0b dlv=%0b inflight=%0d", d + 1, acc, dlv, q.size());
    endtask

    task automatic drain(input int d);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(d);
        cycle(d);
        cycle(d);
    endtask

    task automatic send_vec(input int d, input int i, input logic [3:0] t, input bit ordy);
        drive(d, 1'b1, tbl[i].st, tbl[i].key, tbl[i].last, t, ordy, tbl[i].exp);
        cycle(d);
    endtask

    task automatic send_rand(input int d, input bit v, input bit ordy, input logic [3:0] t);
        logic [127:0] s;
        logic [127:0] k;
        bit           l;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        l = 1'($urandom % 2);
        drive(d, v, s, k, l, t, ordy, model_round(s, k, l));
        cycle(d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
                   1'b0, 4'h3, 128'ha49c7ff2689f352b6b5bea43026a5049};
        tbl[1] = '{128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                   1'b1, 4'h0, 128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{128'ha49c7ff2689f352b6b5bea43026a5049, 128'hf2c295f27a96b9435935807a7359f67f,
                   1'b0, 4'h7, 128'haa8f5f0361dde3ef82d24ad26832469a};
        tbl[3] = '{128'h0, 128'h0, 1'b0, 4'hf, {16{8'h63}}};

        reset = 1'b1;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, '0, 1'b0, 4'h0, 1'b1, '0);
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cur_d = d;
            chk("reset_out_valid", 128'(out_valid[d]), 128'h0);
            chk("reset_out_state", out_state[d], 128'h0);
            chk("reset_out_tag", 128'(out_tag[d]), 128'h0);
            chk("reset_in_ready", 128'(in_ready[d]), 128'h1);
        end
        @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            // known-answer table, one transaction at a time
            for (int i = 0; i < 4; i++) begin
                send_vec(d, i, tbl[i].tag, 1'b1);
                drain(d);
            end
            // streaming, back-to-back
            send_vec(d, 0, 4'h1, 1'b1);
            send_vec(d, 1, 4'h2, 1'b1);
            drain(d);
            // backpressure for five cycles with distinct tags
            for (int i = 0; i < 5; i++) send_rand(d, 1'b1, 1'b0, 4'(8 + i));
            drain(d);
            // key and mode change right after accept
            send_vec(d, 0, 4'h3, 1'b1);
            drive(d, 1'b0, '1, '0, 1'b1, 4'h0, 1'b1, '0);
            drain(d);
            // reset with the pipeline full
            for (int i = 0; i <= d; i++) send_vec(d, 2, 4'(4 + i), 1'b0);
            in_valid[d] = 1'b1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            in_valid[d] = 1'b0;
            q.delete();
            @(negedge clk);
            chk("midreset_out_valid", 128'(out_valid[d]), 128'h0);
            chk("midreset_out_state", out_state[d], 128'h0);
            chk("midreset_out_tag", 128'(out_tag[d]), 128'h0);
            @(posedge clk);
            #1;
            drain(d);
            send_vec(d, 1, 4'h9, 1'b1);
            drain(d);
            // random traffic with random backpressure
            for (int i = 0; i < 300; i++)
                send_rand(d, ($urandom % 4) != 0, ($urandom % 3) != 0, 4'($urandom));
            drain(d);
            drive(d, 1'b0, '0, '0, 1'b0, 4'h0, 1'b1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
